// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU/debug single-port RAM arbiter with fixed CPU priority and dbg starvation guard
module mem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_write,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          busy,
    output logic          owner
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t     state;
    logic       we_q;
    logic [3:0] wait_cnt;
    logic       dbg_win;
    logic       cpu_win;

    always_comb begin
        dbg_win = dbg_req && (!cpu_req || (wait_cnt >= 4'(MAX_WAIT)));
        cpu_win = cpu_req && !dbg_win;
    end

    // Decoded from state so an asynchronous reset kills a write in flight.
    assign ram_write = (state == S_ACCESS) && we_q;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            we_q      <= 1'b0;
            wait_cnt  <= 4'd0;
            owner     <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            cpu_ack   <= 1'b0;
            dbg_ack   <= 1'b0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
        end else begin
            cpu_ack <= 1'b0;
            dbg_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (dbg_win || cpu_win) begin
                        owner    <= dbg_win;
                        ram_addr <= dbg_win ? dbg_addr  : cpu_addr;
                        ram_din  <= dbg_win ? dbg_wdata : cpu_wdata;
                        we_q     <= dbg_win ? dbg_we    : cpu_we;
                        state    <= S_ACCESS;
                    end
                    // Count only losses by a waiting dbg; any dbg grant or idle dbg resets it.
                    if (dbg_win || !dbg_req) begin
                        wait_cnt <= 4'd0;
                    end else if (cpu_win && (wait_cnt != 4'hF)) begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_ACCESS: begin
                    state <= S_RESP;
                    if (owner) begin
                        dbg_ack <= 1'b1;
                    end else begin
                        cpu_ack <= 1'b1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    if (!we_q) begin
                        if (owner) begin
                            dbg_rdata <= ram_dout;
                        end else begin
                            cpu_rdata <= ram_dout;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - table-driven and sequence checks for mem_arbiter with a registered-read RAM model
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [7:0]  cpu_addr, dbg_addr, ram_addr;
    logic [15:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, ram_din, ram_dout;
    logic        cpu_ack, dbg_ack, ram_write, busy, owner;
    logic [15:0] mem [256];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(8), .DW(16), .MAX_WAIT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .ram_addr(ram_addr), .ram_write(ram_write), .ram_din(ram_din), .ram_dout(ram_dout),
        .busy(busy), .owner(owner)
    );

    always @(posedge clk) begin
        if (ram_write) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    typedef struct {
        logic        port;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_cpu;
        logic [15:0] exp_dbg;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_access(input int id, input logic port, input logic we,
                             input logic [7:0] addr, input logic [15:0] wd);
        int  n;
        logic got;
        @(negedge clk);
        if (port) begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        end
        @(negedge clk);
        chk($sformatf("v%0d_access_write", id), ram_write, we);
        chk($sformatf("v%0d_access_addr", id), ram_addr, addr);
        chk($sformatf("v%0d_access_busy", id), busy, 1'b1);
        if (we) chk($sformatf("v%0d_access_din", id), ram_din, wd);
        n = 1;
        got = 1'b0;
        while (!got && n < 8) begin
            @(negedge clk);
            n++;
            got = port ? dbg_ack : cpu_ack;
            chk($sformatf("v%0d_other_ack", id), port ? cpu_ack : dbg_ack, 1'b0);
        end
        chk($sformatf("v%0d_ack_latency", id), n, 2);
        chk($sformatf("v%0d_owner", id), owner, port);
        chk($sformatf("v%0d_resp_write", id), ram_write, 1'b0);
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_ack_drop", id), port ? dbg_ack : cpu_ack, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int acks;
        int last;
        logic seq [10];

        for (int i = 0; i < 256; i++) mem[i] = 16'h0;

        vecs[0]  = '{1'b0, 1'b1, 8'h14, 16'd850,  16'h0000, 16'h0000};
        vecs[1]  = '{1'b0, 1'b0, 8'h14, 16'h0000, 16'h0352, 16'h0000};
        vecs[2]  = '{1'b1, 1'b1, 8'h0E, 16'hE000, 16'h0352, 16'h0000};
        vecs[3]  = '{1'b1, 1'b0, 8'h0E, 16'h0000, 16'h0352, 16'hE000};
        vecs[4]  = '{1'b0, 1'b0, 8'h0E, 16'h0000, 16'hE000, 16'hE000};
        vecs[5]  = '{1'b1, 1'b0, 8'h14, 16'h0000, 16'hE000, 16'h0352};
        vecs[6]  = '{1'b0, 1'b1, 8'hFF, 16'hFFFF, 16'hE000, 16'h0352};
        vecs[7]  = '{1'b0, 1'b0, 8'hFF, 16'h0000, 16'hFFFF, 16'h0352};
        vecs[8]  = '{1'b1, 1'b1, 8'h00, 16'h1234, 16'hFFFF, 16'h0352};
        vecs[9]  = '{1'b1, 1'b0, 8'h00, 16'h0000, 16'hFFFF, 16'h1234};
        vecs[10] = '{1'b0, 1'b1, 8'h05, 16'h5A5A, 16'hFFFF, 16'h1234};
        vecs[11] = '{1'b0, 1'b0, 8'h14, 16'h0000, 16'h0352, 16'h1234};
        vecs[12] = '{1'b1, 1'b0, 8'h0E, 16'h0000, 16'h0352, 16'hE000};

        // Reset held with both requests pending.
        reset_n = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h01; cpu_wdata = 16'h0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h02; dbg_wdata = 16'h0;
        repeat (3) @(negedge clk);
        chk("rst_acks", {cpu_ack, dbg_ack}, 2'b00);
        chk("rst_rdata", {cpu_rdata, dbg_rdata}, 32'h0);
        chk("rst_ram", {ram_addr, ram_din, ram_write}, 25'h0);
        chk("rst_owner_busy", {owner, busy}, 2'b00);
        reset_n = 1'b1;
        n = 0;
        while (!cpu_ack && n < 8) begin
            @(negedge clk);
            n++;
            chk("rst_dbg_ack", dbg_ack, 1'b0);
        end
        chk("rst_cpu_latency", n, 2);
        chk("rst_cpu_owner", owner, 1'b0);
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            do_access(i, vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, vecs[i].exp_cpu);
            chk($sformatf("v%0d_dbg_rdata", i), dbg_rdata, vecs[i].exp_dbg);
        end

        // Request held after ack: one ack every 3 cycles.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h14;
        acks = 0;
        last = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (cpu_ack) begin
                acks++;
                if (last != 0) chk("held_ack_gap", c - last, 3);
                last = c;
            end
        end
        cpu_req = 1'b0;
        chk("held_ack_count", acks, 4);
        @(negedge clk);
        chk("held_idle_busy", busy, 1'b0);

        // Starvation guard: both held, expect C C C C D repeating.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h14;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h0E;
        acks = 0;
        n = 0;
        while (acks < 10 && n < 60) begin
            @(negedge clk);
            n++;
            if (cpu_ack && dbg_ack) chk("starve_both_ack", 1'b1, 1'b0);
            if (cpu_ack || dbg_ack) begin
                seq[acks] = dbg_ack;
                acks++;
            end
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        chk("starve_ack_count", acks, 10);
        for (int k = 0; k < acks; k++)
            chk($sformatf("starve_grant%0d", k), seq[k], (k % 5) == 4);
        @(negedge clk);
        chk("starve_cpu_rdata", cpu_rdata, 16'h0352);
        chk("starve_dbg_rdata", dbg_rdata, 16'hE000);

        // Reset during ACCESS of a write to 0x05.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h05; cpu_wdata = 16'hABCD;
        @(negedge clk);
        chk("midrst_access_write", ram_write, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_write_drop", ram_write, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        cpu_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("midrst_no_ack", cpu_ack, 1'b0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        chk("midrst_mem_kept", mem[8'h05], 16'h5A5A);
        do_access(99, 1'b1, 1'b0, 8'h05, 16'h0);
        chk("midrst_readback", dbg_rdata, 16'h5A5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
